// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requesting master and the bit-serial adder controller.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             OV;

  modport master (output start, a, b, cin, input busy, done, sum, cout, OV);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, OV);
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full adder walks WIDTH-bit operands LSB first,
// one bit per clock, behind a start/busy/done handshake.
module full_adder (
  input  logic a0,
  input  logic a1,
  input  logic c0,
  output logic s,
  output logic c1
);
  assign s  = a0 ^ a1 ^ c0;
  assign c1 = (a0 & a1) | (c0 & (a0 ^ a1));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             CLR,
  serial_add_ctrl_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ov_q, ov_d;
  logic             fa_s, fa_c1;
  logic [WIDTH-1:0] sum_next;

  full_adder u_fa (
    .a0 (a_sh_q[0]),
    .a1 (b_sh_q[0]),
    .c0 (carry_q),
    .s  (fa_s),
    .c1 (fa_c1)
  );

  // New bit enters at the top; on the last bit this is the complete result.
  assign sum_next = {fa_s, sum_sh_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ov_d     = ov_q;
    if (CLR) begin
      state_d  = IDLE;
      cnt_d    = '0;
      carry_d  = 1'b0;
      a_sh_d   = '0;
      b_sh_d   = '0;
      sum_sh_d = '0;
      sum_d    = '0;
      cout_d   = 1'b0;
      ov_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
        RUN: begin
          a_sh_d   = a_sh_q >> 1;
          b_sh_d   = b_sh_q >> 1;
          sum_sh_d = sum_next[WIDTH-1:1];
          carry_d  = fa_c1;
          if (cnt_q == LAST) begin
            // carry_q here is the carry into the MSB
            sum_d   = sum_next;
            cout_d  = fa_c1;
            ov_d    = carry_q ^ fa_c1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ov_q     <= ov_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.OV   = ov_q;
endmodule
